multicycle_controller: RTL

Control FSM for the multicycle RV32I core. Sequences the shared datapath: PC/instruction register, ALU operand muxes, immediate extender, result mux and register file. Supports lw, sw, R-type, I-type ALU, beq, jal and lui. Adds a memory-ready handshake, an illegal-opcode trap and a retired-instruction counter.

---
 rtl/multicycle_controller.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM for the multicycle RV32I core with memory-ready
// handshake, illegal-opcode trap and retired-instruction counter.
module multicycle_controller #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          op,
    input  logic                zero,
    input  logic                mem_ready,
    output logic [2:0]          immsrc,
    output logic [1:0]          alusrca,
    output logic [1:0]          alusrcb,
    output logic [1:0]          resultsrc,
    output logic [1:0]          aluop,
    output logic                adrsrc,
    output logic                irwrite,
    output logic                pcwrite,
    output logic                regwrite,
    output logic                memwrite,
    output logic                illegal,
    output logic [3:0]          state,
    output logic [RETIRE_W-1:0] retired
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR,
        EXECI, JAL, LUI, ALUWB, BEQ, TRAP
    } state_t;

    state_t              state_q, state_d;
    logic [RETIRE_W-1:0] retired_q;
    logic                pcupdate, branch, retire, fetch_rdy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) retired_q <= retired_q + RETIRE_W'(1);
        end
    end

    always_comb begin
        immsrc = (op == 7'b0100011) ? 3'b001 :
                 (op == 7'b1100011) ? 3'b010 :
                 (op == 7'b1101111) ? 3'b011 :
                 (op == 7'b0110111) ? 3'b100 : 3'b000;
    end

    // Reset gates the fetch handshake so no PC/IR load leaks out while reset is held.
    assign fetch_rdy = mem_ready & ~reset;

    always_comb begin
        state_d   = state_q;
        alusrca   = 2'b00;
        alusrcb   = 2'b00;
        resultsrc = 2'b00;
        aluop     = 2'b00;
        adrsrc    = 1'b0;
        irwrite   = 1'b0;
        pcupdate  = 1'b0;
        branch    = 1'b0;
        regwrite  = 1'b0;
        memwrite  = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            FETCH: begin
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                irwrite   = fetch_rdy;
                pcupdate  = fetch_rdy;
                state_d   = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                state_d = (op == 7'b0000011 || op == 7'b0100011) ? MEMADR :
                          (op == 7'b0110011) ? EXECR :
                          (op == 7'b0010011) ? EXECI :
                          (op == 7'b1101111) ? JAL :
                          (op == 7'b1100011) ? BEQ :
                          (op == 7'b0110111) ? LUI : TRAP;
            end
            MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                state_d = (op == 7'b0000011) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adrsrc  = 1'b1;
                state_d = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                resultsrc = 2'b01;
                regwrite  = 1'b1;
                state_d   = FETCH;
            end
            MEMWRITE: begin
                adrsrc   = 1'b1;
                memwrite = 1'b1;
                state_d  = mem_ready ? FETCH : MEMWRITE;
            end
            EXECR: begin
                alusrca = 2'b10;
                aluop   = 2'b10;
                state_d = ALUWB;
            end
            EXECI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluop   = 2'b10;
                state_d = ALUWB;
            end
            JAL: begin
                alusrca  = 2'b01;
                alusrcb  = 2'b10;
                pcupdate = 1'b1;
                state_d  = ALUWB;
            end
            LUI: begin
                alusrca = 2'b11;
                alusrcb = 2'b01;
                state_d = ALUWB;
            end
            ALUWB: begin
                regwrite = 1'b1;
                state_d  = FETCH;
            end
            BEQ: begin
                alusrca = 2'b10;
                aluop   = 2'b01;
                branch  = 1'b1;
                state_d = FETCH;
            end
            TRAP: begin
                illegal = 1'b1;
                state_d = TRAP;
            end
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        retire = (state_q == MEMWB) || (state_q == ALUWB) || (state_q == BEQ) ||
                 (state_q == MEMWRITE && mem_ready);
    end

    assign pcwrite = pcupdate | (branch & zero);
    assign state   = state_q;
    assign retired = retired_q;
endmodule
